// File: rtl/rf_mover.sv
// rf_mover -- register-file row mover.
//
// Copies cmd_len rows from a source region of a single-ported register file
// to a destination region, one row every two cycles (read, then write).
// Either address may be held fixed so the mover can drain an MMIO read port
// or stream into an MMIO write port instead of walking a memory range.
//
// Ports
//   clk          in   1          only clock
//   rst          in   1          synchronous active-high reset
//   cmd_valid    in   1          a command is presented
//   cmd_ready    out  1          a command can be accepted (IDLE or FIN)
//   cmd_src      in   RF_ADDR_W  first source row address
//   cmd_dst      in   RF_ADDR_W  first destination row address
//   cmd_len      in   LEN_W      number of rows to move
//   cmd_src_inc  in   1          1: source advances per row, 0: held
//   cmd_dst_inc  in   1          1: destination advances per row, 0: held
//   busy         out  1          transfer in progress (RD or WR)
//   done         out  1          one-cycle completion pulse (FIN)
//   ram_addr     out  RF_ADDR_W  register-file address
//   ram_data     out  RF_DATA_W  register-file write data
//   ram_re       out  1          register-file read enable
//   ram_we       out  1          register-file write enable
//   ram_q        in   RF_DATA_W  read data, valid the cycle after ram_re

module rf_mover #(
  parameter int RF_DATA_W = 1408,
  parameter int RF_ADDR_W = 10,
  parameter int LEN_W     = 10
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [RF_ADDR_W-1:0] cmd_src,
  input  logic [RF_ADDR_W-1:0] cmd_dst,
  input  logic [LEN_W-1:0]     cmd_len,
  input  logic                 cmd_src_inc,
  input  logic                 cmd_dst_inc,
  output logic                 busy,
  output logic                 done,
  output logic [RF_ADDR_W-1:0] ram_addr,
  output logic [RF_DATA_W-1:0] ram_data,
  output logic                 ram_re,
  output logic                 ram_we,
  input  logic [RF_DATA_W-1:0] ram_q
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    FIN  = 2'd3
  } state_t;

  state_t               state_r;
  state_t               state_nx_s;

  // Latched command: running addresses, remaining-row count, step bits.
  logic [RF_ADDR_W-1:0] src_r;
  logic [RF_ADDR_W-1:0] dst_r;
  logic [LEN_W-1:0]     cnt_r;
  logic                 src_inc_r;
  logic                 dst_inc_r;

  logic                 accept_s;
  logic                 len_zero_s;
  logic                 last_row_s;

  // cmd_ready depends only on the state register, so this has no comb loop.
  assign accept_s   = cmd_valid & cmd_ready;
  assign len_zero_s = (cmd_len == {LEN_W{1'b0}});
  // cnt_r holds the rows still to be written, including the one in WR now.
  assign last_row_s = (cnt_r == {{(LEN_W-1){1'b0}}, 1'b1});

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          state_nx_s = len_zero_s ? FIN : RD;
        end else begin
          state_nx_s = IDLE;
        end
      end
      RD: begin
        state_nx_s = WR;
      end
      WR: begin
        if (last_row_s) begin
          state_nx_s = FIN;
        end else begin
          state_nx_s = RD;
        end
      end
      FIN: begin
        // A command offered during FIN starts straight away.
        if (accept_s) begin
          state_nx_s = len_zero_s ? FIN : RD;
        end else begin
          state_nx_s = IDLE;
        end
      end
      default: begin
        state_nx_s = IDLE;
      end
    endcase
  end

  // Command latch and per-row address/count advance.
  always_ff @(posedge clk) begin
    if (rst) begin
      src_r     <= {RF_ADDR_W{1'b0}};
      dst_r     <= {RF_ADDR_W{1'b0}};
      cnt_r     <= {LEN_W{1'b0}};
      src_inc_r <= 1'b0;
      dst_inc_r <= 1'b0;
    end else if (accept_s) begin
      src_r     <= cmd_src;
      dst_r     <= cmd_dst;
      cnt_r     <= cmd_len;
      src_inc_r <= cmd_src_inc;
      dst_inc_r <= cmd_dst_inc;
    end else if (state_r == WR) begin
      // Addresses wrap naturally at 2^RF_ADDR_W.
      src_r <= src_r + {{(RF_ADDR_W-1){1'b0}}, src_inc_r};
      dst_r <= dst_r + {{(RF_ADDR_W-1){1'b0}}, dst_inc_r};
      cnt_r <= cnt_r - {{(LEN_W-1){1'b0}}, 1'b1};
    end else begin
      src_r     <= src_r;
      dst_r     <= dst_r;
      cnt_r     <= cnt_r;
      src_inc_r <= src_inc_r;
      dst_inc_r <= dst_inc_r;
    end
  end

  // Output decode from the state register; write data is ram_q passed
  // straight through so the row read in RD is written in the next cycle.
  always_comb begin
    cmd_ready = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    ram_re    = 1'b0;
    ram_we    = 1'b0;
    ram_addr  = {RF_ADDR_W{1'b0}};
    ram_data  = {RF_DATA_W{1'b0}};
    case (state_r)
      IDLE: begin
        cmd_ready = 1'b1;
      end
      RD: begin
        busy     = 1'b1;
        ram_re   = 1'b1;
        ram_addr = src_r;
      end
      WR: begin
        busy     = 1'b1;
        ram_we   = 1'b1;
        ram_addr = dst_r;
        ram_data = ram_q;
      end
      FIN: begin
        cmd_ready = 1'b1;
        done      = 1'b1;
      end
      default: begin
        cmd_ready = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_rf_mover.sv
// tb_rf_mover -- directed self-checking bench for rf_mover.
// A behavioural register file answers the DUT; a separate expectation array
// tracks what every row should hold after each commanded copy.

module tb_rf_mover;

  localparam int DW = 1408;
  localparam int AW = 10;
  localparam int LW = 10;

  logic          clk;
  logic          rst;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [AW-1:0] cmd_src;
  logic [AW-1:0] cmd_dst;
  logic [LW-1:0] cmd_len;
  logic          cmd_src_inc;
  logic          cmd_dst_inc;
  logic          busy;
  logic          done;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_data;
  logic          ram_re;
  logic          ram_we;
  logic [DW-1:0] ram_q;

  logic [DW-1:0] mem [1024];
  logic [DW-1:0] ex  [1024];
  bit            mem_init;

  int total;
  int bad;
  int ncmd;
  int ndone;

  rf_mover #(.RF_DATA_W(DW), .RF_ADDR_W(AW), .LEN_W(LW)) dut (
    .clk        (clk),
    .rst        (rst),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_src    (cmd_src),
    .cmd_dst    (cmd_dst),
    .cmd_len    (cmd_len),
    .cmd_src_inc(cmd_src_inc),
    .cmd_dst_inc(cmd_dst_inc),
    .busy       (busy),
    .done       (done),
    .ram_addr   (ram_addr),
    .ram_data   (ram_data),
    .ram_re     (ram_re),
    .ram_we     (ram_we),
    .ram_q      (ram_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [DW-1:0] row_pat(input logic [AW-1:0] a);
    logic [DW-1:0] r;
    for (int k = 0; k < DW / 32; k++) begin
      r[k*32 +: 32] = {a, 6'(k), 16'hC3A5 ^ 16'(k * 7)};
    end
    return r;
  endfunction

  // Behavioural single-port register file with one-cycle read latency.
  always @(posedge clk) begin
    if (!mem_init) begin
      for (int i = 0; i < 1024; i++) mem[i] <= row_pat(AW'(i));
      mem_init <= 1'b1;
    end else begin
      if (ram_re) ram_q <= mem[ram_addr];
      if (ram_we) mem[ram_addr] <= ram_data;
    end
  end

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Port exclusivity every cycle, and a running count of done pulses.
  always @(negedge clk) begin
    check_val("re_we_excl", {63'd0, ram_re & ram_we}, 64'd0);
    if (done === 1'b1) ndone++;
  end

  task automatic idle_check(input string tag);
    check_val({tag, "_ready"}, cmd_ready, 1);
    check_val({tag, "_busy"},  busy,      0);
    check_val({tag, "_done"},  done,      0);
    check_val({tag, "_re"},    ram_re,    0);
    check_val({tag, "_we"},    ram_we,    0);
    check_val({tag, "_addr"},  ram_addr,  0);
    check_val({tag, "_data0"}, {63'd0, |ram_data}, 0);
  endtask

  // Called at a negedge while the DUT is in IDLE or FIN; returns at the
  // negedge of the FIN cycle with cmd_valid low.
  task automatic issue(input logic [AW-1:0] s, input logic [AW-1:0] d, input logic [LW-1:0] len,
                       input logic si, input logic di, input bit noise);
    logic [AW-1:0] sa;
    logic [AW-1:0] da;
    logic [DW-1:0] row;
    int last;
    sa = s;
    da = d;
    last = 2 * int'(len) + 1;
    cmd_valid = 1'b1; cmd_src = s; cmd_dst = d; cmd_len = len;
    cmd_src_inc = si; cmd_dst_inc = di;
    check_val("acc_ready", cmd_ready, 1);
    @(posedge clk);
    ncmd++;
    for (int c = 1; c <= last; c++) begin
      @(negedge clk);
      if (c == last) begin
        check_val("fin_done",  done,     1);
        check_val("fin_busy",  busy,     0);
        check_val("fin_re",    ram_re,   0);
        check_val("fin_we",    ram_we,   0);
        check_val("fin_addr",  ram_addr, 0);
        check_val("fin_data0", {63'd0, |ram_data}, 0);
        check_val("fin_ready", cmd_ready, 1);
      end else if ((c % 2) == 1) begin
        check_val("rd_re",    ram_re,    1);
        check_val("rd_we",    ram_we,    0);
        check_val("rd_addr",  ram_addr,  sa);
        check_val("rd_busy",  busy,      1);
        check_val("rd_done",  done,      0);
        check_val("rd_ready", cmd_ready, 0);
      end else begin
        row = ex[sa];
        check_val("wr_we",    ram_we,   1);
        check_val("wr_re",    ram_re,   0);
        check_val("wr_addr",  ram_addr, da);
        check_val("wr_busy",  busy,     1);
        check_val("wr_data_lo", ram_data[63:0], row[63:0]);
        check_val("wr_data_eq", {63'd0, ram_data === row}, 1);
        ex[da] = row;
        sa = sa + {9'd0, si};
        da = da + {9'd0, di};
      end
      // Junk commands while busy must be ignored; never offer one into FIN.
      if (noise && c < last - 1) begin
        cmd_valid = 1'b1; cmd_src = ~s; cmd_dst = ~d; cmd_len = 10'h3FF;
        cmd_src_inc = ~si; cmd_dst_inc = ~di;
      end else begin
        cmd_valid = 1'b0;
      end
    end
  endtask

  initial begin
    int nmis;
    total = 0; bad = 0; ncmd = 0; ndone = 0;
    for (int i = 0; i < 1024; i++) ex[i] = row_pat(AW'(i));
    rst = 1'b1; cmd_valid = 1'b0; cmd_src = 10'd0; cmd_dst = 10'd0;
    cmd_len = 10'd0; cmd_src_inc = 1'b0; cmd_dst_inc = 1'b0;
    repeat (3) @(negedge clk);
    check_val("rst_busy", busy,     0);
    check_val("rst_done", done,     0);
    check_val("rst_re",   ram_re,   0);
    check_val("rst_we",   ram_we,   0);
    check_val("rst_addr", ram_addr, 0);
    rst = 1'b0;
    @(negedge clk);
    idle_check("post_rst");

    // Plain ascending copy of three rows.
    issue(10'h010, 10'h020, 10'd3, 1'b1, 1'b1, 1'b0);
    @(negedge clk);
    idle_check("idle1");

    // Fixed source (MMIO drain) with junk commands offered while busy.
    issue(10'h208, 10'h100, 10'd4, 1'b0, 1'b1, 1'b1);
    @(negedge clk);
    idle_check("idle2");

    // Zero-length command, then a back-to-back overlapping copy from FIN.
    issue(10'h0AA, 10'h0BB, 10'd0, 1'b1, 1'b1, 1'b0);
    issue(10'h030, 10'h031, 10'd2, 1'b1, 1'b1, 1'b0);
    check_val("ovl_row31", {63'd0, mem[10'h031] === row_pat(10'h030)}, 1);
    @(negedge clk);
    check_val("ovl_row32", {63'd0, mem[10'h032] === row_pat(10'h030)}, 1);
    idle_check("idle3");

    // Destination wraps from all-ones to zero.
    issue(10'h150, 10'h3FF, 10'd2, 1'b1, 1'b1, 1'b0);
    @(negedge clk);
    check_val("wrap_row0", {63'd0, mem[10'h000] === row_pat(10'h151)}, 1);

    // Reset during cycle 4 of a five-row transfer.
    cmd_valid = 1'b1; cmd_src = 10'h040; cmd_dst = 10'h050; cmd_len = 10'd5;
    cmd_src_inc = 1'b1; cmd_dst_inc = 1'b1;
    check_val("ab_ready", cmd_ready, 1);
    @(posedge clk);
    @(negedge clk); cmd_valid = 1'b0;
    check_val("ab_rd0", ram_addr, 10'h040);
    @(negedge clk);
    check_val("ab_wr0", ram_addr, 10'h050);
    @(negedge clk);
    check_val("ab_rd1", ram_addr, 10'h041);
    @(negedge clk);
    check_val("ab_wr1_we", ram_we, 1);
    rst = 1'b1;
    @(negedge clk);
    check_val("ab_re",   ram_re, 0);
    check_val("ab_we",   ram_we, 0);
    check_val("ab_busy", busy,   0);
    check_val("ab_done", done,   0);
    rst = 1'b0;
    @(negedge clk);
    idle_check("ab_idle");
    ex[10'h050] = ex[10'h040];
    ex[10'h051] = ex[10'h041];
    check_val("ab_kept0", {63'd0, mem[10'h050] === ex[10'h050]}, 1);
    check_val("ab_kept1", {63'd0, mem[10'h051] === ex[10'h051]}, 1);
    check_val("ab_untouched", {63'd0, mem[10'h052] === ex[10'h052]}, 1);
    issue(10'h060, 10'h070, 10'd2, 1'b1, 1'b1, 1'b0);
    @(negedge clk);

    // Random commands, gaps and junk offers.
    for (int n = 0; n < 20; n++) begin
      issue(AW'($urandom_range(0, 1023)), AW'($urandom_range(0, 1023)),
            LW'($urandom_range(0, 6)), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      for (int g = $urandom_range(0, 2); g > 0; g--) begin
        @(negedge clk);
        idle_check("rnd_gap");
      end
    end
    @(negedge clk);

    // Maximum length: 1023 rows from a fixed source.
    issue(10'h005, 10'h000, 10'h3FF, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    idle_check("max_idle");

    nmis = 0;
    for (int i = 0; i < 1024; i++) if (mem[i] !== ex[i]) nmis++;
    check_val("mem_final", nmis, 0);
    check_val("done_count", ndone, ncmd);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rf_mover.md
RF_MOVER -- requirements
Module: rf_mover

Interface
REQ-001 Parameters: RF_DATA_W, default 1408, row width in bits.
REQ-002 Parameters: RF_ADDR_W, default 10, register-file address width.
REQ-003 Parameters: LEN_W, default 10, row-count field width.
REQ-004 The block SHALL use one clock, clk, and a synchronous, active-high reset, rst; ports are listed as name, direction, width, meaning.
REQ-005 clk  in  1  the only clock.
REQ-006 rst  in  1  synchronous active-high reset.
REQ-007 cmd_valid  in  1  a command is presented.
REQ-008 cmd_ready  out  1  the block can accept a command.
REQ-009 cmd_src  in  RF_ADDR_W  first source row address.
REQ-010 cmd_dst  in  RF_ADDR_W  first destination row address.
REQ-011 cmd_len  in  LEN_W  number of rows to move.
REQ-012 cmd_src_inc  in  1  1 increments the source address per row; 0 holds it fixed, for draining an MMIO Y port.
REQ-013 cmd_dst_inc  in  1  1 increments the destination address per row; 0 holds it fixed, for streaming into an MMIO X port.
REQ-014 busy  out  1  a transfer is in progress.
REQ-015 done  out  1  one-cycle pulse when a transfer completes.
REQ-016 ram_addr  out  RF_ADDR_W  register-file address.
REQ-017 ram_data  out  RF_DATA_W  register-file write data.
REQ-018 ram_re  out  1  register-file read enable.
REQ-019 ram_we  out  1  register-file write enable.
REQ-020 ram_q  in  RF_DATA_W  register-file read data, valid the cycle after ram_re.

Function
REQ-021 The controller SHALL have states IDLE, RD, WR and FIN.
REQ-022 A command SHALL be accepted on a cycle with cmd_valid=1 and cmd_ready=1; src, dst, len, src_inc and dst_inc SHALL be latched on that cycle.
REQ-023 cmd_ready SHALL be 1 only in IDLE and FIN; a command accepted in FIN SHALL begin in the next cycle, back-to-back.
REQ-024 Transitions: accept with len>0 -> RD; accept with len=0 -> FIN; RD -> WR; WR -> RD if rows remain, otherwise FIN; FIN -> IDLE when no command is accepted.
REQ-025 RD: ram_re=1, ram_we=0, ram_addr=current source address.
REQ-026 WR: ram_we=1, ram_re=0, ram_addr=current destination address, ram_data=ram_q passed combinationally with no extra register.
REQ-027 In IDLE and FIN, ram_re=0, ram_we=0, ram_addr=0 and ram_data=0.
REQ-028 ram_re and ram_we SHALL never both be 1 in the same cycle, because the port is single-ported.
REQ-029 After each WR, the source address SHALL advance by cmd_src_inc and the destination address by cmd_dst_inc, both modulo 2^RF_ADDR_W (all-ones wraps to 0).
REQ-030 Timing: with acceptance at cycle 0 and len=L>0, row i (0-based) SHALL be read at cycle 2i+1 and written at cycle 2i+2, and done SHALL be 1 at cycle 2L+1; with len=0, done SHALL be 1 at cycle 1 and no access SHALL occur.
REQ-031 busy SHALL be 1 in RD and WR only.
REQ-032 done SHALL be 1 only in FIN, for exactly one cycle per command.
REQ-033 Overlapping ranges SHALL copy in ascending row order, each row read before it is written; no overlap detection is performed.
REQ-034 cmd_valid while not ready SHALL be ignored, and the latched command SHALL be unaffected.
REQ-035 The row counter SHALL be LEN_W bits wide; cmd_len equal to all-ones SHALL move 2^LEN_W-1 rows.

Reset
REQ-036 rst=1 at any clock edge, including mid-transfer, SHALL force IDLE and clear the counters and latched command.
REQ-037 From the next cycle after reset: cmd_ready=1 (once rst=0), busy=0, done=0, ram_re=0, ram_we=0, ram_addr=0, ram_data=0.
REQ-038 An aborted transfer SHALL NOT produce done, and rows already written SHALL remain written.

Verification
REQ-039 src=0x010, dst=0x020, len=3, both inc=1 -> reads at 0x010, 0x011, 0x012 on cycles 1, 3, 5; writes at 0x020, 0x021, 0x022 on cycles 2, 4, 6 with data equal to the model row; done on cycle 7.
REQ-040 src=0x208, src_inc=0, dst=0x100, len=4 -> four reads of 0x208 and writes to 0x100..0x103, each carrying the ram_q value of the preceding cycle.
REQ-041 len=0 -> done on cycle 1, no re/we ever, busy never 1; then a second command with cmd_valid held during FIN -> accepted in FIN, RD on the following cycle.
REQ-042 dst=0x3FF, dst_inc=1, len=2 -> writes to 0x3FF then 0x000.
REQ-043 rst asserted on cycle 4 of a len=5 transfer -> cycle 5 has re=we=0, busy=0, and no done pulse occurs; a new command then completes normally.
REQ-044 Random commands with a random cmd_valid stream -> the re/we exclusivity assertion holds, and exactly one done pulse occurs per accepted command.
